// File: rtl/dlsc_address_decoder_pipe_pkg.sv
// Shared types for the registered address decoder pipe.
// Holds the skid-buffer occupancy state encoding used by the top module.
package dlsc_address_decoder_pipe_pkg;

  // EMPTY: output register empty; ONE: output full, skid empty; FULL: both full
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/dlsc_address_decoder_pipe_if.sv
// Address-channel bus of the decoder pipe: upstream valid/ready beat in,
// decoded beat with match information out.
// slave  : the decoder (consumes in_*, produces out_*)
// master : the environment (produces in_*, consumes out_*)
interface dlsc_address_decoder_pipe_if #(
  parameter int unsigned ADDR    = 32,
  parameter int unsigned USER    = 1,
  parameter int unsigned RANGES  = 1,
  parameter int unsigned RANGESB = 1
);

  logic                in_valid;
  logic                in_ready;
  logic [ADDR-1:0]     in_addr;
  logic [USER-1:0]     in_user;

  logic                out_valid;
  logic                out_ready;
  logic [ADDR-1:0]     out_addr;
  logic [USER-1:0]     out_user;
  logic                out_match_valid;
  logic [RANGES-1:0]   out_match_onehot;
  logic [RANGESB-1:0]  out_match;

  modport slave (
    input  in_valid, in_addr, in_user, out_ready,
    output in_ready, out_valid, out_addr, out_user,
           out_match_valid, out_match_onehot, out_match
  );

  modport master (
    output in_valid, in_addr, in_user, out_ready,
    input  in_ready, out_valid, out_addr, out_user,
           out_match_valid, out_match_onehot, out_match
  );

endinterface

// File: rtl/dlsc_address_match.sv
// Combinational priority match of an address against RANGES base/mask pairs.
// Range 0 has highest priority; disabled ranges never hit.
// Ports: i_addr, i_range_en in; o_match_valid_c, o_match_onehot_c, o_match_c out.
module dlsc_address_match #(
  parameter int unsigned            ADDR    = 32,
  parameter int unsigned            RANGES  = 1,
  parameter int unsigned            RANGESB = 1,
  parameter logic [RANGES*ADDR-1:0] MASKS   = '0,
  parameter logic [RANGES*ADDR-1:0] BASES   = '0
) (
  input  logic [ADDR-1:0]    i_addr,
  input  logic [RANGES-1:0]  i_range_en,
  output logic               o_match_valid_c,
  output logic [RANGES-1:0]  o_match_onehot_c,
  output logic [RANGESB-1:0] o_match_c
);

  // First hitting range in ascending order wins; later hits are ignored
  always_comb begin
    o_match_valid_c  = 1'b0;
    o_match_onehot_c = '0;
    o_match_c        = '0;
    for (int unsigned i = 0; i < RANGES; i++) begin
      if (!o_match_valid_c && i_range_en[i] &&
          ((i_addr & ~MASKS[i*ADDR +: ADDR]) ==
           (BASES[i*ADDR +: ADDR] & ~MASKS[i*ADDR +: ADDR]))) begin
        o_match_valid_c     = 1'b1;
        o_match_onehot_c[i] = 1'b1;
        o_match_c           = RANGESB'(i);
      end
    end
  end

endmodule

// File: rtl/dlsc_address_decoder_pipe.sv
// Registered, flow-controlled address decoder with a two-entry skid buffer.
// Beats are decoded at acceptance and the result travels with the beat.
// Ports: clk, rst_n (async active-low), range_en (per-range enable),
//        bus (slave: in_* handshake in, decoded out_* handshake out),
//        miss_count (saturating no-match count), miss_clear (sync clear).
module dlsc_address_decoder_pipe
  import dlsc_address_decoder_pipe_pkg::*;
#(
  parameter int unsigned            ADDR    = 32,
  parameter int unsigned            USER    = 1,
  parameter int unsigned            RANGES  = 1,
  parameter int unsigned            RANGESB = 1,
  parameter logic [RANGES*ADDR-1:0] MASKS   = '0,
  parameter logic [RANGES*ADDR-1:0] BASES   = '0,
  parameter int unsigned            CNTB    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RANGES-1:0]          range_en,
  dlsc_address_decoder_pipe_if.slave bus,
  output logic [CNTB-1:0]            miss_count,
  input  logic                       miss_clear
);

  localparam logic [CNTB-1:0] CNT_MAX = '1;

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_drain;
  logic w_load_or_in;
  logic w_load_or_sr;
  logic w_load_sr;

  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_mv;
  logic [RANGES-1:0]  w_oh;
  logic [RANGESB-1:0] w_idx;

  logic [ADDR-1:0]    r_or_addr,  r_sr_addr;
  logic [USER-1:0]    r_or_user,  r_sr_user;
  logic               r_or_mv,    r_sr_mv;
  logic [RANGES-1:0]  r_or_oh,    r_sr_oh;
  logic [RANGESB-1:0] r_or_idx,   r_sr_idx;

  logic [CNTB-1:0]    r_miss_count;

  // Input-side decode, stored with the beat on acceptance
  dlsc_address_match #(
    .ADDR    (ADDR),
    .RANGES  (RANGES),
    .RANGESB (RANGESB),
    .MASKS   (MASKS),
    .BASES   (BASES)
  ) u_match (
    .i_addr           (bus.in_addr),
    .i_range_en       (range_en),
    .o_match_valid_c  (w_mv),
    .o_match_onehot_c (w_oh),
    .o_match_c        (w_idx)
  );

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_drain  = r_out_valid && bus.out_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Next-state and entry load controls
  always_comb begin
    w_state_nxt  = r_state;
    w_load_or_in = 1'b0;
    w_load_or_sr = 1'b0;
    w_load_sr    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_or_in = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_drain && w_accept) begin
          w_load_or_in = 1'b1;
        end else if (w_drain) begin
          w_state_nxt  = ST_EMPTY;
        end else if (w_accept) begin
          w_load_sr    = 1'b1;
          w_state_nxt  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_load_or_sr = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output register: filled from the input or promoted from the skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_addr <= '0;
      r_or_user <= '0;
      r_or_mv   <= 1'b0;
      r_or_oh   <= '0;
      r_or_idx  <= '0;
    end else if (w_load_or_in) begin
      r_or_addr <= bus.in_addr;
      r_or_user <= bus.in_user;
      r_or_mv   <= w_mv;
      r_or_oh   <= w_oh;
      r_or_idx  <= w_idx;
    end else if (w_load_or_sr) begin
      r_or_addr <= r_sr_addr;
      r_or_user <= r_sr_user;
      r_or_mv   <= r_sr_mv;
      r_or_oh   <= r_sr_oh;
      r_or_idx  <= r_sr_idx;
    end
  end

  // Skid register: catches the beat accepted while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr_addr <= '0;
      r_sr_user <= '0;
      r_sr_mv   <= 1'b0;
      r_sr_oh   <= '0;
      r_sr_idx  <= '0;
    end else if (w_load_sr) begin
      r_sr_addr <= bus.in_addr;
      r_sr_user <= bus.in_user;
      r_sr_mv   <= w_mv;
      r_sr_oh   <= w_oh;
      r_sr_idx  <= w_idx;
    end
  end

  // Saturating miss counter; clear wins over a simultaneous miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_count <= '0;
    end else if (miss_clear) begin
      r_miss_count <= '0;
    end else if (w_accept && !w_mv && (r_miss_count != CNT_MAX)) begin
      r_miss_count <= r_miss_count + CNTB'(1);
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_addr         = r_or_addr;
  assign bus.out_user         = r_or_user;
  assign bus.out_match_valid  = r_or_mv;
  assign bus.out_match_onehot = r_or_oh;
  assign bus.out_match        = r_or_idx;
  assign miss_count           = r_miss_count;

endmodule

// File: tb/tb_dlsc_address_decoder_pipe.sv
// Self-checking bench for dlsc_address_decoder_pipe (3 ranges, 2-bit miss counter).
module tb_dlsc_address_decoder_pipe;

  localparam int unsigned ADDR = 32;
  localparam int unsigned USER = 4;
  localparam int unsigned RANGES = 3;
  localparam int unsigned RANGESB = 2;
  localparam int unsigned CNTB = 2;
  localparam logic [RANGES*ADDR-1:0] MASKS = {32'h0FFF_FFFF, 32'h00FF_FFFF, 32'h0000_FFFF};
  localparam logic [RANGES*ADDR-1:0] BASES = {32'h1000_0000, 32'h1000_0000, 32'h0000_0000};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RANGES-1:0] range_en;
  logic [CNTB-1:0]   miss_count;
  logic              miss_clear;

  dlsc_address_decoder_pipe_if #(.ADDR(ADDR), .USER(USER), .RANGES(RANGES), .RANGESB(RANGESB)) bus ();

  dlsc_address_decoder_pipe #(
    .ADDR(ADDR), .USER(USER), .RANGES(RANGES), .RANGESB(RANGESB),
    .MASKS(MASKS), .BASES(BASES), .CNTB(CNTB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .range_en   (range_en),
    .bus        (bus),
    .miss_count (miss_count),
    .miss_clear (miss_clear)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] base [3] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_0000};
  logic [31:0] mask [3] = '{32'h0000_FFFF, 32'h00FF_FFFF, 32'h0FFF_FFFF};
  logic [41:0] sb [$];   // {addr, user, match_valid, onehot, index} in acceptance order
  int occ = 0;           // beats held in the pipe
  int mcnt = 0;          // expected miss count
  int n_drain = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Spec rule: lowest enabled range whose unmasked bits equal the base
  task automatic decode(input logic [31:0] a, input logic [2:0] en,
                        output logic mv, output logic [2:0] oh, output logic [1:0] idx);
    mv = 1'b0; oh = 3'b000; idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (en[i] && (((a ^ base[i]) & ~mask[i]) == 32'h0)) begin
        mv = 1'b1; oh = 3'(1 << i); idx = 2'(i);
      end
    end
  endtask

  // One clock with inputs as currently driven; model advances alongside
  task automatic cycle();
    logic acc, drn, mv;
    logic [2:0] oh;
    logic [1:0] idx;
    logic [41:0] e;
    mv = 1'b1; oh = '0; idx = '0;
    @(negedge clk);
    acc = bus.in_valid && (occ < 2);
    drn = (occ > 0) && bus.out_ready;
    if (occ > 0) begin
      e = sb[0];
      chk("out_valid_held", 64'(bus.out_valid), 64'(1));
      chk("out_addr", 64'(bus.out_addr), 64'(e[41:10]));
      chk("out_user", 64'(bus.out_user), 64'(e[9:6]));
      chk("out_match_valid", 64'(bus.out_match_valid), 64'(e[5]));
      chk("out_match_onehot", 64'(bus.out_match_onehot), 64'(e[4:2]));
      chk("out_match", 64'(bus.out_match), 64'(e[1:0]));
    end
    if (drn) begin
      void'(sb.pop_front());
      n_drain++;
    end
    if (acc) begin
      decode(bus.in_addr, range_en, mv, oh, idx);
      sb.push_back({bus.in_addr, bus.in_user, mv, oh, idx});
    end
    if (miss_clear) mcnt = 0;
    else if (acc && !mv && mcnt < 3) mcnt++;
    occ = occ + int'(acc) - int'(drn);
    @(posedge clk);
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(occ < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(occ > 0));
    chk("miss_count", 64'(miss_count), 64'(mcnt));
  endtask

  // Offer one beat for one cycle with the current out_ready
  task automatic send(input logic [31:0] a);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_user  = 4'($urandom);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_miss_count"}, 64'(miss_count), 64'(0));
    chk({tag, "_match_valid"}, 64'(bus.out_match_valid), 64'(0));
    chk({tag, "_onehot"}, 64'(bus.out_match_onehot), 64'(0));
    chk({tag, "_match"}, 64'(bus.out_match), 64'(0));
    chk({tag, "_addr"}, 64'(bus.out_addr), 64'(0));
    chk({tag, "_user"}, 64'(bus.out_user), 64'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return {16'h0000, 16'($urandom)};
      2:       return {8'h10, 24'($urandom)};
      3:       return {4'h1, 28'($urandom)};
      default: return {4'h2, 28'($urandom)};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    range_en = 3'b111;
    miss_clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr = '0;
    bus.in_user = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Overlap priority
    bus.out_ready = 1'b1;
    send(32'h1000_1234);
    chk("ovl1_match", 64'(bus.out_match), 64'(1));
    chk("ovl1_onehot", 64'(bus.out_match_onehot), 64'(3'b010));
    cycle();
    send(32'h1F00_0000);
    chk("ovl2_match", 64'(bus.out_match), 64'(2));
    chk("ovl2_onehot", 64'(bus.out_match_onehot), 64'(3'b100));
    cycle();
    send(32'h0000_ABCD);
    chk("ovl0_match", 64'(bus.out_match), 64'(0));
    chk("ovl0_onehot", 64'(bus.out_match_onehot), 64'(3'b001));
    cycle();

    // Miss
    send(32'h2000_0000);
    chk("miss_valid", 64'(bus.out_match_valid), 64'(0));
    chk("miss_onehot", 64'(bus.out_match_onehot), 64'(0));
    chk("miss_cnt1", 64'(miss_count), 64'(1));
    cycle();

    // Run-time disable, then toggle enables while the beat is stalled
    bus.out_ready = 1'b0;
    range_en = 3'b101;
    send(32'h1000_1234);
    chk("dis_match", 64'(bus.out_match), 64'(2));
    chk("dis_onehot", 64'(bus.out_match_onehot), 64'(3'b100));
    range_en = 3'b010;
    cycle();
    chk("dis_hold_match", 64'(bus.out_match), 64'(2));
    bus.out_ready = 1'b1;
    cycle();
    range_en = 3'b111;

    // Backpressure: two accepted, third refused until the skid drains
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_addr = 32'h0000_0001; bus.in_user = 4'h1; cycle();
    bus.in_addr = 32'h1000_0002; bus.in_user = 4'h2; cycle();
    chk("bp_full_ready", 64'(bus.in_ready), 64'(0));
    bus.in_addr = 32'h1F00_0003; bus.in_user = 4'h3; cycle();
    chk("bp_still_full", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_ready_back", 64'(bus.in_ready), 64'(1));
    chk("bp_second_addr", 64'(bus.out_addr), 64'(32'h1000_0002));
    cycle();
    cycle();

    // Saturation (counter currently 1) and clear-over-miss priority
    for (int i = 0; i < 5; i++) send(32'h2000_0000 + 32'(i));
    cycle();
    chk("sat_cnt", 64'(miss_count), 64'(3));
    miss_clear = 1'b1;
    send(32'h3000_0000);
    miss_clear = 1'b0;
    chk("clear_cnt", 64'(miss_count), 64'(0));
    cycle();

    // Reset while FULL
    bus.out_ready = 1'b0;
    send(32'h0000_1111);
    send(32'h1000_2222);
    chk("full_before_rst", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("rst_full_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_full_in_ready", 64'(bus.in_ready), 64'(1));
    check_reset_outputs("rst_full");
    sb.delete();
    occ = 0;
    mcnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Throughput with both sides held high
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    n_drain = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_addr = rand_addr();
      bus.in_user = 4'($urandom);
      cycle();
    end
    chk("throughput", 64'(n_drain), 64'(19));
    bus.in_valid = 1'b0;
    cycle();

    // Random streaming
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_addr   = rand_addr();
      bus.in_user   = 4'($urandom);
      miss_clear    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) range_en = 3'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    miss_clear = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
